// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage driving a single-port data memory; MEM_TIMEOUT_EN adds a 15-cycle access timeout.
// Latency: 1 cycle for non-memory ops, 1 + N cycles for aligned loads/stores (N = WAIT cycles incl. the ack cycle).
// Backpressure: stall freezes upstream while an aligned access is launched or awaiting dmem_ack.
module mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] aluresult,
  input  logic [31:0] storedata,
  input  logic [4:0]  rd,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic [31:0] aluresultout,
  output logic [31:0] readdataout,
  output logic [4:0]  rdout,
  output logic        MemtoRegout,
  output logic        RegWriteout,
  output logic        misalign,
  output logic        dmem_err
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [4:0]  rd;
    logic        mtr;
    logic        rw;
  } mem_req_t;

  state_t   state;
  state_t   state_nxt;
  mem_req_t cap;

  logic memop;
  logic aligned;
  logic start;
  logic misop;
  logic pass;
  logic done;
  logic timeout;

  assign memop   = MemRead | MemWrite;
  assign aligned = (aluresult[1:0] == 2'b00);

`ifdef MEM_TIMEOUT_EN
  logic [3:0] wait_cnt;

  // Counts unacknowledged WAIT cycles; the 15th one without ack gives up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 4'd0;
    end else if (start) begin
      wait_cnt <= 4'd0;
    end else if (state == WAIT && !dmem_ack) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  assign timeout = (state == WAIT) && !dmem_ack && (wait_cnt == 4'd14);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_err <= 1'b0;
    end else begin
      dmem_err <= timeout;
    end
  end
`else
  assign timeout  = 1'b0;
  assign dmem_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (memop && aligned) state_nxt = WAIT;
      WAIT: if (dmem_ack || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gated by rst_n so stall and the request drop the instant reset asserts.
  always_comb begin
    stall    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    start    = 1'b0;
    misop    = 1'b0;
    pass     = 1'b0;
    done     = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          start = memop & aligned;
          misop = memop & ~aligned;
          pass  = ~memop;
          stall = memop & aligned;
        end
        WAIT: begin
          dmem_req = 1'b1;
          dmem_we  = cap.we;
          done     = dmem_ack;
          stall    = ~dmem_ack;
        end
        default: ;
      endcase
    end
  end

  assign dmem_addr  = cap.addr;
  assign dmem_wdata = cap.wdata;

  // MemWrite wins when both strobes are set, so a read+write is a store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap <= '0;
    end else if (start) begin
      cap.addr  <= aluresult;
      cap.wdata <= storedata;
      cap.we    <= MemWrite;
      cap.rd    <= rd;
      cap.mtr   <= MemtoReg;
      cap.rw    <= RegWrite;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluresultout <= 32'd0;
      readdataout  <= 32'd0;
      rdout        <= 5'd0;
      MemtoRegout  <= 1'b0;
      RegWriteout  <= 1'b0;
    end else if (done) begin
      aluresultout <= cap.addr;
      rdout        <= cap.rd;
      MemtoRegout  <= cap.mtr;
      RegWriteout  <= cap.rw & ~cap.we;
      if (!cap.we) begin
        readdataout <= dmem_rdata;
      end
    end else if (pass) begin
      aluresultout <= aluresult;
      rdout        <= rd;
      MemtoRegout  <= MemtoReg;
      RegWriteout  <= RegWrite;
    end else begin
      // Launch, pending WAIT, timeout and misaligned ops all retire as bubbles.
      RegWriteout <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign <= 1'b0;
    end else begin
      misalign <= misop;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage: transaction-level model, memory responder, retirement monitor.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] aluresult = 32'd0;
  logic [31:0] storedata = 32'd0;
  logic [4:0]  rd = 5'd0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic        MemtoReg = 1'b0;
  logic        RegWrite = 1'b0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        stall;
  logic [31:0] aluresultout;
  logic [31:0] readdataout;
  logic [4:0]  rdout;
  logic        MemtoRegout;
  logic        RegWriteout;
  logic        misalign;
  logic        dmem_err;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .aluresult(aluresult), .storedata(storedata), .rd(rd),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall(stall),
    .aluresultout(aluresultout), .readdataout(readdataout), .rdout(rdout),
    .MemtoRegout(MemtoRegout), .RegWriteout(RegWriteout),
    .misalign(misalign), .dmem_err(dmem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rdat;
    logic [4:0]  rd;
    logic        mtr;
    logic        rw;
    logic        mis;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        we;
    int          dly;   // ack in this WAIT cycle; 0 = never ack
  } req_t;

  exp_t exp_q[$];
  req_t req_q[$];
  exp_t last;
  logic [31:0] model_mem [logic [31:0]];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic set_nop();
    aluresult = 32'd0; storedata = 32'd0; rd = 5'd0;
    MemRead = 1'b0; MemWrite = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0;
  endtask

  // Present one instruction, record the architectural outcome, hold until upstream may advance.
  task automatic issue(input logic rdq, input logic wrq, input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] r, input logic mtr, input logic rw, input int dly);
    exp_t e;
    req_t q;
    logic s;
    int   n;
    e = last;
    e.mis = 1'b0;
    e.lat = 1;
    if (!(rdq || wrq)) begin
      e.alu = a; e.rd = r; e.mtr = mtr; e.rw = rw;
    end else if (a % 4 != 0) begin
      e.rw = 1'b0; e.mis = 1'b1;
    end else begin
      q.addr = a; q.wdata = wd; q.we = wrq; q.dly = dly;
      e.alu = a; e.rd = r; e.mtr = mtr; e.lat = 1 + dly;
      if (wrq) begin
        e.rw = 1'b0;
        model_mem[a] = wd;
        q.rdata = $urandom;
      end else begin
        e.rw = rw;
        q.rdata = mem_rd(a);
        e.rdat = q.rdata;
      end
      req_q.push_back(q);
    end
    last = e;
    exp_q.push_back(e);
    aluresult = a; storedata = wd; rd = r;
    MemRead = rdq; MemWrite = wrq; MemtoReg = mtr; RegWrite = rw;
    n = 0;
    do begin
      @(negedge clk);
      s = stall;
      @(posedge clk);
      #1;
      n++;
    end while (s && n < 200);
    if (s) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout: stall still %b after %0d cycles, required 0", s, n);
    end
  endtask

  // Data memory: acks in the requested WAIT cycle, sprinkles stray acks while idle.
  initial begin : responder
    req_t q;
    int   cnt;
    logic active;
    active = 1'b0; cnt = 0;
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
    q.addr = 0; q.wdata = 0; q.rdata = 0; q.we = 0; q.dly = 1;
    forever begin
      @(posedge clk);
      #1;
      if (dmem_req === 1'b1) begin
        if (!active) begin
          active = 1'b1;
          cnt = 0;
          if (req_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_req: dmem_req 1 addr %h, required no request", dmem_addr);
            q.dly = 1; q.we = 0; q.rdata = 0;
          end else begin
            q = req_q.pop_front();
            chk("dmem_addr", dmem_addr, q.addr);
            chk("dmem_we", 32'(dmem_we), 32'(q.we));
            if (q.we) chk("dmem_wdata", dmem_wdata, q.wdata);
          end
        end
        cnt++;
        dmem_ack = (cnt == q.dly);
        dmem_rdata = dmem_ack ? q.rdata : $urandom;
      end else begin
        active = 1'b0;
        dmem_ack = ($urandom_range(0, 3) == 0);
        dmem_rdata = $urandom;
      end
    end
  end

  // Retirement monitor: an edge with stall low retires the presented instruction.
  initial begin : monitor
    exp_t e;
    int   cyc;
    logic pre_stall;
    logic pre_en;
    cyc = 0;
    forever begin
      @(negedge clk);
      pre_stall = stall;
      pre_en = mon_en;
      @(posedge clk);
      #2;
      if (!pre_en) begin
        cyc = 0;
      end else begin
        cyc++;
        chk("dmem_err_idle", 32'(dmem_err), 32'd0);
        if (pre_stall) begin
          chk("bubble_regwrite", 32'(RegWriteout), 32'd0);
          chk("misalign_quiet", 32'(misalign), 32'd0);
        end else if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_retire: retired with empty scoreboard, required none");
        end else begin
          e = exp_q.pop_front();
          chk("aluresultout", aluresultout, e.alu);
          chk("readdataout", readdataout, e.rdat);
          chk("rdout", 32'(rdout), 32'(e.rd));
          chk("MemtoRegout", 32'(MemtoRegout), 32'(e.mtr));
          chk("RegWriteout", 32'(RegWriteout), 32'(e.rw));
          chk("misalign", 32'(misalign), 32'(e.mis));
          chk("latency", 32'(cyc), 32'(e.lat));
          cyc = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [31:0] a;
    logic        rdq;
    logic        wrq;
    int          k;
    req_t        q;
    last.alu = 0; last.rdat = 0; last.rd = 0; last.mtr = 0; last.rw = 0; last.mis = 0; last.lat = 0;

    // Reset with an aligned load presented: nothing may request or stall.
    aluresult = 32'h100; MemRead = 1'b1; RegWrite = 1'b1;
    #12;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_dmem_err", 32'(dmem_err), 32'd0);
    chk("rst_aluresultout", aluresultout, 32'd0);
    chk("rst_readdataout", readdataout, 32'd0);
    chk("rst_rdout", 32'(rdout), 32'd0);
    chk("rst_RegWriteout", 32'(RegWriteout), 32'd0);
    chk("rst_MemtoRegout", 32'(MemtoRegout), 32'd0);
    set_nop();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Directed: ALU op, 3-cycle load, 1-cycle store with RegWrite set, misaligned load.
    issue(1'b0, 1'b0, 32'h1234, 32'd0, 5'd5, 1'b0, 1'b1, 1);
    model_mem[32'h100] = 32'hDEADBEEF;
    issue(1'b1, 1'b0, 32'h100, 32'd0, 5'd7, 1'b1, 1'b1, 3);
    issue(1'b0, 1'b1, 32'h204, 32'hCAFEF00D, 5'd9, 1'b0, 1'b1, 1);
    issue(1'b1, 1'b0, 32'h102, 32'd0, 5'd3, 1'b1, 1'b1, 1);
    issue(1'b1, 1'b1, 32'h204, 32'h0BADF00D, 5'd4, 1'b0, 1'b1, 2);
    issue(1'b1, 1'b0, 32'h204, 32'd0, 5'd6, 1'b1, 1'b1, 1);

    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 3);
      rdq = (k == 1) || (k == 3);
      wrq = (k == 2) || (k == 3);
      a = 32'h100 + 32'($urandom_range(0, 15)) * 4;
      if (k == 0) a = $urandom;
      else if ($urandom_range(0, 4) == 0) a = a + 32'($urandom_range(1, 3));
      issue(rdq, wrq, a, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(1, 5));
    end

    set_nop();
    mon_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("requests_drained", 32'(req_q.size()), 32'd0);

`ifdef MEM_TIMEOUT_EN
    begin : timeout_test
      int wc;
      q.addr = 32'h180; q.wdata = 0; q.rdata = 0; q.we = 1'b0; q.dly = 0;
      req_q.push_back(q);
      aluresult = 32'h180; MemRead = 1'b1; RegWrite = 1'b1; rd = 5'd2;
      wc = 0;
      for (int c = 0; c < 40; c++) begin
        @(posedge clk);
        #1;
        if (dmem_err) break;
        if (dmem_req) wc++;
      end
      set_nop();
      chk("timeout_err", 32'(dmem_err), 32'd1);
      chk("timeout_wait_cycles", 32'(wc), 32'd15);
      chk("timeout_req_dropped", 32'(dmem_req), 32'd0);
      chk("timeout_bubble", 32'(RegWriteout), 32'd0);
      @(posedge clk);
      #1;
      chk("timeout_err_pulse", 32'(dmem_err), 32'd0);
    end
`endif

    // Reset asserted mid-WAIT abandons the access.
    q.addr = 32'h100; q.wdata = 0; q.rdata = 0; q.we = 1'b0; q.dly = 0;
    req_q.push_back(q);
    aluresult = 32'h100; MemRead = 1'b1; RegWrite = 1'b1; rd = 5'd1;
    repeat (3) @(posedge clk);
    #1;
    chk("midwait_req_before", 32'(dmem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midwait_rst_req", 32'(dmem_req), 32'd0);
    chk("midwait_rst_stall", 32'(stall), 32'd0);
    chk("midwait_rst_we", 32'(dmem_we), 32'd0);
    chk("midwait_rst_alu", aluresultout, 32'd0);
    chk("midwait_rst_rdata", readdataout, 32'd0);
    chk("midwait_rst_rd", 32'(rdout), 32'd0);
    chk("midwait_rst_rw", 32'(RegWriteout), 32'd0);
    chk("midwait_rst_addr", dmem_addr, 32'd0);
    set_nop();
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("post_rst_no_req", 32'(dmem_req), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
